cpu_issuer: RTL and testbench
=============================

# cpu_issuer

Instruction issuer for the stream CPU. It accepts decoded commands (opcode, operand A, operand B) from a host or test sequencer and encodes each one into a 16-bit instruction word. It drives that word on an AXI-Stream master into the CPU's slave port, then collects the result from the CPU's master port. It also computes the expected result locally, reports pass, fail or timeout per command, and keeps saturating statistics counters.

## Interface
Parameters:
- DATA_WIDTH, 16: instruction and result width. Must be ≥ 16.
- TIMEOUT_CYCLES, 64: maximum number of cycles from entering SEND to receiving a response.
- CNT_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  single clock.
- rstn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer can accept a command.
- cmd_opcode  in  4  operation: 0 ADD, 1 OR, 2 AND, 3 SHR.
- cmd_opa  in  6  operand A.
- cmd_opb  in  6  operand B.
- axim_tvalid  out  1  instruction valid, to the CPU.
- axim_tready  in  1  CPU accepts the instruction.
- axim_tdata  out  DATA_WIDTH  encoded instruction.
- axis_tvalid  in  1  result valid, from the CPU.
- axis_tready  out  1  issuer accepts the result.
- axis_tdata  in  DATA_WIDTH  result from the CPU.
- rsp_valid  out  1  one-cycle report strobe.
- rsp_data  out  DATA_WIDTH  received result; 0 on timeout or illegal opcode.
- rsp_match  out  1  received result equals the expected result.
- rsp_timeout  out  1  no response within TIMEOUT_CYCLES.
- rsp_illegal  out  1  opcode > 3.
- pass_cnt, fail_cnt, timeout_cnt  out  CNT_WIDTH each  saturating statistics counters.
- err_sticky  out  1  set on any timeout; cleared only by reset.

## Operation
- Instruction encoding: axim_tdata[3:0]=opcode, [9:4]=opA, [15:10]=opB; all bits above 15 are 0.
- Expected result, zero-extended to DATA_WIDTH:
  - ADD: 7-bit sum.
  - OR, AND: 6-bit result.
  - SHR: opA >> opB; any opB ≥ 6 gives 0.
- State machine: IDLE, SEND, WAIT_RSP, REPORT.
  - IDLE: cmd_ready=1.
    - On cmd_valid, capture the command and expected value.
    - Opcode ≤ 3: go to SEND.
    - Opcode > 3: go to REPORT with rsp_illegal=1. No stream traffic is generated.
  - SEND: axim_tvalid=1. axim_tdata is held stable until the handshake. On axim_tready, go to WAIT_RSP.
  - WAIT_RSP: axis_tready=1. On axis_tvalid, capture axis_tdata, set rsp_match = (data == expected), and go to REPORT.
  - REPORT: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Counter updates in REPORT:
  - pass_cnt increments on a match.
  - fail_cnt increments on a mismatch.
  - timeout_cnt increments on a timeout.
  - An illegal opcode updates no counter.
  - All counters saturate at all-ones.
- Timeout:
  - The timer is cleared on entry to SEND and increments in SEND and WAIT_RSP.
  - When the timer reaches TIMEOUT_CYCLES-1 without the pending handshake completing, go to REPORT with rsp_timeout=1, rsp_match=0 and err_sticky=1.
  - If the handshake and the timeout expiry occur in the same cycle, the handshake wins.
- axis_tready is 0 outside WAIT_RSP. A late response stalls at the CPU and is consumed by the next command. err_sticky flags that the stream is out of sync.

## Timing
- Reset values: all outputs 0, except cmd_ready=1 (state IDLE). Counters, timer and err_sticky are 0.
- Registered outputs: all handshake and report outputs come directly from state or registers. There is no combinational path from an input to an output.
- Pipeline: at most one instruction is outstanding.
- Minimum command-to-report latency with zero-wait peers:
  - Cycle 0: command accepted.
  - Cycle 1: SEND handshake.
  - Cycle 2: response received.
  - Cycle 3: rsp_valid.
  - cmd_ready returns in cycle 4.
- Illegal opcode: rsp_valid occurs in the cycle after acceptance.
- Stream stability: once asserted, axim_tvalid stays high until axim_tready. axim_tdata must not change while axim_tvalid is high.
- Mid-operation reset: an asynchronous reset in any state returns the block to IDLE with all outputs at reset values. Any half-sent instruction is abandoned.

## Structure
- Package cpu_pkg holds:
  - opcode localparams (OP_ADD=0, OP_OR=1, OP_AND=2, OP_SHR=3);
  - instruction field positions (OPC_LSB=0, OPA_LSB=4, OPB_LSB=10, field widths 4/6/6);
  - the state encoding.
- The CPU and the issuer share this package.
- Sub-module cpu_ref_alu: a combinational expected-result model, reusable by testbenches.

## Test plan
- ADD: command op=0, A=63, B=63; stream model returns 126 → axim_tdata=0xFFF0, rsp_match=1, pass_cnt=1.
- SHR: op=3, A=40, B=7; stream model returns 0 → axim_tdata=0x1E83, rsp_match=1. In a second run the model returns 5 → rsp_match=0, fail_cnt=1.
- Backpressure: hold axim_tready low for 10 cycles, then high → axim_tvalid and axim_tdata stay stable throughout, and exactly one transfer occurs.
- Timeout: with TIMEOUT_CYCLES=64, never assert axis_tvalid → rsp_timeout=1 exactly 64 cycles after entering SEND, timeout_cnt=1, err_sticky=1.
- Illegal opcode: op=9 → no axim_tvalid, rsp_illegal=1 in the next cycle, all counters unchanged.
- Reset during WAIT_RSP: assert rstn low → all outputs return to reset values immediately; the next command completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the stream CPU and its issuer: opcodes, the
// instruction field layout and the issuer state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_SHR = 4'd3;

  localparam int OPC_LSB = 0;
  localparam int OPA_LSB = 4;
  localparam int OPB_LSB = 10;
  localparam int OPC_W   = 4;
  localparam int OPA_W   = 6;
  localparam int OPB_W   = 6;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  function automatic logic [15:0] encode_instr(input logic [OPC_W-1:0] opc,
                                               input logic [OPA_W-1:0] opa,
                                               input logic [OPB_W-1:0] opb);
    logic [15:0] w;
    w = '0;
    w[OPC_LSB +: OPC_W] = opc;
    w[OPA_LSB +: OPA_W] = opa;
    w[OPB_LSB +: OPB_W] = opb;
    return w;
  endfunction

endpackage

// File: rtl/cpu_ref_alu.sv
// Combinational expected-result model of the stream CPU; results are
// zero-extended to DATA_WIDTH and illegal opcodes yield 0.
module cpu_ref_alu
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [OPC_W-1:0]      opcode,
  input  logic [OPA_W-1:0]      opa,
  input  logic [OPB_W-1:0]      opb,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  illegal
);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (opcode)
      OP_ADD: result[OPA_W:0]   = {1'b0, opa} + {1'b0, opb};
      OP_OR:  result[OPA_W-1:0] = opa | opb;
      OP_AND: result[OPA_W-1:0] = opa & opb;
      OP_SHR: result[OPA_W-1:0] = (opb >= OPB_W'(OPA_W)) ? '0 : (opa >> opb);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_issuer.sv
// Issues one encoded instruction at a time to the stream CPU, checks the
// returned result against the local reference and keeps statistics.
module cpu_issuer
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_opcode,
  input  logic [5:0]            cmd_opa,
  input  logic [5:0]            cmd_opb,
  output logic                  axim_tvalid,
  input  logic                  axim_tready,
  output logic [DATA_WIDTH-1:0] axim_tdata,
  input  logic                  axis_tvalid,
  output logic                  axis_tready,
  input  logic [DATA_WIDTH-1:0] axis_tdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_match,
  output logic                  rsp_timeout,
  output logic                  rsp_illegal,
  output logic [CNT_WIDTH-1:0]  pass_cnt,
  output logic [CNT_WIDTH-1:0]  fail_cnt,
  output logic [CNT_WIDTH-1:0]  timeout_cnt,
  output logic                  err_sticky
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [TMR_W-1:0]      timer_q, timer_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] exp_q, exp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  match_q, match_d;
  logic                  tmo_q, tmo_d;
  logic                  ill_q, ill_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  pass_q, fail_q, tcnt_q;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_illegal;
  logic                  timer_expired;

  cpu_ref_alu #(.DATA_WIDTH(DATA_WIDTH)) u_ref_alu (
    .opcode  (cmd_opcode),
    .opa     (cmd_opa),
    .opb     (cmd_opb),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  assign timer_expired = (timer_q >= TMR_LAST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    instr_d = instr_q;
    exp_d   = exp_q;
    rdata_d = rdata_q;
    match_d = match_q;
    tmo_d   = tmo_q;
    ill_d   = ill_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          instr_d = DATA_WIDTH'(encode_instr(cmd_opcode, cmd_opa, cmd_opb));
          exp_d   = alu_result;
          timer_d = '0;
          if (alu_illegal) begin
            ill_d   = 1'b1;
            state_d = ST_REPORT;
          end else begin
            state_d = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        timer_d = timer_q + 1'b1;
        if (axim_tready) begin
          state_d = ST_WAIT;
        end else if (timer_expired) begin
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_REPORT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A response arriving in the expiry cycle still counts as on time.
        if (axis_tvalid) begin
          rdata_d = axis_tdata;
          match_d = (axis_tdata == exp_q);
          state_d = ST_REPORT;
        end else if (timer_expired) begin
          tmo_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_REPORT;
        end
      end
      default: begin
        rdata_d = '0;
        match_d = 1'b0;
        tmo_d   = 1'b0;
        ill_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      instr_q <= '0;
      exp_q   <= '0;
      rdata_q <= '0;
      match_q <= 1'b0;
      tmo_q   <= 1'b0;
      ill_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      instr_q <= instr_d;
      exp_q   <= exp_d;
      rdata_q <= rdata_d;
      match_q <= match_d;
      tmo_q   <= tmo_d;
      ill_q   <= ill_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pass_q <= '0;
      fail_q <= '0;
      tcnt_q <= '0;
    end else if (state_q == ST_REPORT && !ill_q) begin
      if (tmo_q) begin
        if (tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;
      end else if (match_q) begin
        if (pass_q != '1) pass_q <= pass_q + 1'b1;
      end else begin
        if (fail_q != '1) fail_q <= fail_q + 1'b1;
      end
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign axim_tvalid = (state_q == ST_SEND);
  assign axim_tdata  = instr_q;
  assign axis_tready = (state_q == ST_WAIT);
  assign rsp_valid   = (state_q == ST_REPORT);
  assign rsp_data    = rdata_q;
  assign rsp_match   = match_q;
  assign rsp_timeout = tmo_q;
  assign rsp_illegal = ill_q;
  assign pass_cnt    = pass_q;
  assign fail_cnt    = fail_q;
  assign timeout_cnt = tcnt_q;
  assign err_sticky  = err_q;

endmodule

// File: tb/tb_cpu_issuer.sv
// Directed and randomized checks of cpu_issuer against a behavioural model
// of command results, stream timing, timeouts and statistics.
module tb_cpu_issuer;

  localparam int DW = 16;
  localparam int TO = 64;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode;
  logic [5:0]    cmd_opa, cmd_opb;
  logic          axim_tvalid, axim_tready;
  logic [DW-1:0] axim_tdata;
  logic          axis_tvalid, axis_tready;
  logic [DW-1:0] axis_tdata;
  logic          rsp_valid, rsp_match, rsp_timeout, rsp_illegal;
  logic [DW-1:0] rsp_data;
  logic [CW-1:0] pass_cnt, fail_cnt, timeout_cnt;
  logic          err_sticky;

  int n_assert = 0;
  int n_fail   = 0;
  int m_pass   = 0;
  int m_fail   = 0;
  int m_tmo    = 0;
  bit m_err    = 1'b0;

  always #5 clk = ~clk;

  cpu_issuer #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_opa(cmd_opa), .cmd_opb(cmd_opb),
    .axim_tvalid(axim_tvalid), .axim_tready(axim_tready), .axim_tdata(axim_tdata),
    .axis_tvalid(axis_tvalid), .axis_tready(axis_tready), .axis_tdata(axis_tdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_match(rsp_match),
    .rsp_timeout(rsp_timeout), .rsp_illegal(rsp_illegal),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt),
    .err_sticky(err_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_result(input int op, input int a, input int b);
    case (op)
      0: return a + b;
      1: return a | b;
      2: return a & b;
      3: return (b >= 6) ? 0 : (a >> b);
      default: return 0;
    endcase
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_pass_cnt"}, 32'(pass_cnt), 32'(m_pass));
    chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
    chk({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'(m_tmo));
    chk({tag, "_err_sticky"}, 32'(err_sticky), 32'(m_err));
  endtask

  // tr_wait: SEND cycles with tready low; rs_wait: WAIT cycles before the
  // response; abort_at: bench cycle (1 = first cycle after accept) to reset in.
  task automatic run_cmd(input string tag, input int op, input int a, input int b,
                         input int tr_wait, input int rs_wait, input bit respond,
                         input int rval, input int abort_at);
    int exp_res, cyc, xfers, rsp_idx, exp_lat;
    bit illegal, tmo, match;
    logic [15:0] instr;
    illegal = (op > 3);
    exp_res = ref_result(op, a, b);
    instr   = 16'(op + a * 16 + b * 1024);
    rsp_idx = tr_wait + 1 + rs_wait;
    tmo     = !illegal && (!respond || tr_wait > TO - 1 || rsp_idx > TO - 1);
    match   = !illegal && !tmo && (rval == exp_res);
    exp_lat = illegal ? 1 : (tmo ? TO + 1 : rsp_idx + 2);

    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_opcode = 4'(op);
    cmd_opa    = 6'(a);
    cmd_opb    = 6'(b);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc   = 1;
    xfers = 0;
    while (!rsp_valid && cyc < 200) begin
      if (abort_at == cyc) begin
        rstn = 1'b0;
        #1;
        chk({tag, "_rst_cmd_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rst_axim_tvalid"}, 32'(axim_tvalid), 32'd0);
        chk({tag, "_rst_axim_tdata"}, 32'(axim_tdata), 32'd0);
        chk({tag, "_rst_axis_tready"}, 32'(axis_tready), 32'd0);
        chk({tag, "_rst_rsp_valid"}, 32'(rsp_valid), 32'd0);
        m_pass = 0; m_fail = 0; m_tmo = 0; m_err = 1'b0;
        chk_counters({tag, "_rst"});
        @(negedge clk);
        rstn        = 1'b1;
        axim_tready = 1'b0;
        axis_tvalid = 1'b0;
        @(negedge clk);
        return;
      end
      if (!illegal && cyc - 1 <= tr_wait && cyc - 1 < TO)
        chk({tag, "_axim_tvalid_hold"}, 32'(axim_tvalid), 32'd1);
      if (axim_tvalid) chk({tag, "_axim_tdata"}, 32'(axim_tdata), 32'(instr));
      if (!illegal && !tmo && cyc - 1 == tr_wait + 1)
        chk({tag, "_axis_tready"}, 32'(axis_tready), 32'd1);
      axim_tready = (cyc - 1 >= tr_wait);
      axis_tvalid = respond && (cyc - 1 >= rsp_idx);
      axis_tdata  = DW'(rval);
      if (axim_tvalid && axim_tready) xfers++;
      @(negedge clk);
      cyc++;
    end
    axim_tready = 1'b0;
    axis_tvalid = 1'b0;

    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_transfers"}, 32'(xfers), (illegal || tr_wait > TO - 1) ? 32'd0 : 32'd1);
    chk({tag, "_axim_tvalid_rpt"}, 32'(axim_tvalid), 32'd0);
    chk({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'(illegal));
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(tmo));
    chk({tag, "_rsp_match"}, 32'(rsp_match), 32'(match));
    chk({tag, "_rsp_data"}, 32'(rsp_data), (illegal || tmo) ? 32'd0 : 32'(rval));

    if (tmo) begin
      if (m_tmo < 65535) m_tmo++;
      m_err = 1'b1;
    end else if (!illegal) begin
      if (match) begin
        if (m_pass < 65535) m_pass++;
      end else begin
        if (m_fail < 65535) m_fail++;
      end
    end
    if (tmo) chk({tag, "_err_with_rsp"}, 32'(err_sticky), 32'd1);

    @(negedge clk);
    chk({tag, "_rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    chk_counters(tag);
  endtask

  initial begin
    int op, a, b, tw, rw, rv;
    bit resp;
    rstn        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_opcode  = '0;
    cmd_opa     = '0;
    cmd_opb     = '0;
    axim_tready = 1'b0;
    axis_tvalid = 1'b0;
    axis_tdata  = '0;
    repeat (3) @(negedge clk);

    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_axim_tvalid", 32'(axim_tvalid), 32'd0);
    chk("reset_axim_tdata", 32'(axim_tdata), 32'd0);
    chk("reset_axis_tready", 32'(axis_tready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_flags", {28'd0, rsp_match, rsp_timeout, rsp_illegal, 1'b0}, 32'd0);
    chk("reset_rsp_data", 32'(rsp_data), 32'd0);
    chk_counters("reset");
    rstn = 1'b1;
    @(negedge clk);

    run_cmd("add_max", 0, 63, 63, 0, 0, 1'b1, 126, 0);
    run_cmd("shr_zero", 3, 40, 7, 0, 0, 1'b1, 0, 0);
    run_cmd("shr_bad", 3, 40, 7, 0, 0, 1'b1, 5, 0);
    run_cmd("shr_inrange", 3, 40, 3, 0, 2, 1'b1, 5, 0);
    run_cmd("backpressure", 1, 21, 42, 10, 1, 1'b1, 63, 0);
    run_cmd("illegal", 9, 5, 6, 0, 0, 1'b1, 11, 0);
    run_cmd("timeout", 2, 15, 12, 0, 0, 1'b0, 0, 0);
    run_cmd("last_cycle_rsp", 2, 15, 12, 0, 62, 1'b1, 12, 0);
    run_cmd("one_too_late", 0, 1, 2, 0, 63, 1'b1, 3, 0);
    run_cmd("send_timeout", 0, 1, 2, 70, 0, 1'b1, 3, 0);
    run_cmd("reset_in_wait", 0, 7, 8, 0, 0, 1'b0, 0, 5);
    run_cmd("after_reset", 0, 7, 8, 0, 0, 1'b1, 15, 0);

    for (int i = 0; i < 40; i++) begin
      op   = $urandom_range(0, 5);
      a    = $urandom_range(0, 63);
      b    = $urandom_range(0, 63);
      tw   = $urandom_range(0, 6);
      rw   = $urandom_range(0, 6);
      resp = ($urandom_range(0, 9) != 0);
      rv   = ($urandom_range(0, 3) != 0) ? ref_result(op, a, b) : $urandom_range(0, 127);
      run_cmd("random", op, a, b, tw, rw, resp, rv, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
